// File: rtl/rocketcpu_wb_sample_dma.sv
// rocketcpu_wb_sample_dma: Wishbone initiator that streams DSP samples into a
// circular buffer in CPU memory, one 32-bit single write per sample.
// Optional feature: define ROCKETCPU_DMA_IRQ_EN to add o_irq / i_irq_mask.
//
// The FIFO head is moved into o_wb_dat when a transfer is launched, so the
// slot it occupied is free while the write is in flight; the ack (or the
// timeout) retires that sample. This lets depth-4 FIFO plus the in-flight
// word hold five samples.

module rocketcpu_wb_sample_dma #(
  parameter int unsigned FIFO_AW = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst_n,
  input  logic        i_en,
  input  logic [31:0] i_base_adr,
  input  logic [15:0] i_len,
  input  logic [31:0] i_sample,
  input  logic        i_sample_stb,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic        i_wb_ack,
  output logic [15:0] o_wr_idx,
  output logic        o_busy,
  output logic        o_overflow,
  output logic        o_timeout
`ifdef ROCKETCPU_DMA_IRQ_EN
  ,
  output logic        o_irq,
  input  logic [1:0]  i_irq_mask
`endif
);

  localparam int unsigned Depth   = 1 << FIFO_AW;
  localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StGap} state_e;

  state_e             state_q;
  logic [31:0]        fifo_mem [Depth];
  logic [FIFO_AW:0]   wr_ptr_q, rd_ptr_q;
  logic               fifo_empty, fifo_full;
  logic               push_req, push, pop, drop, flush;
  logic [15:0]        len_q;
  logic [15:0]        tmo_cnt_q;
  logic [15:0]        idx_next;
  logic [31:0]        base_aligned;
  logic               xfer_done;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);

  // Launch pops the head; a full FIFO can still accept a push that cycle.
  assign pop      = (state_q == StIdle) && i_en && !fifo_empty;
  assign flush    = (state_q == StIdle) && !i_en;
  assign push_req = i_sample_stb && i_en && (i_len != 16'd0);
  assign push     = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;

  assign base_aligned = i_base_adr & 32'hFFFF_FFFC;
  assign xfer_done    = i_wb_ack || (tmo_cnt_q == TmoLast);
  assign o_busy       = (state_q != StIdle) || !fifo_empty;

  // Next buffer index; an index at or past the end (len shrank) wraps to 0.
  always_comb begin
    idx_next = o_wr_idx + 16'd1;
    if ((len_q == 16'd0) || (o_wr_idx >= len_q - 16'd1)) begin
      idx_next = 16'd0;
    end
  end

  // Sample storage; no reset needed, validity is tracked by the pointers.
  always_ff @(posedge i_wb_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= i_sample;
    end
  end

  // FIFO pointers, cleared by reset or by a disable flush.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Transfer FSM with registered bus outputs, index and sticky flags.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_q    <= StIdle;
      o_wb_adr   <= '0;
      o_wb_dat   <= '0;
      o_wb_sel   <= '0;
      o_wb_we    <= 1'b0;
      o_wb_cyc   <= 1'b0;
      o_wr_idx   <= '0;
      o_overflow <= 1'b0;
      o_timeout  <= 1'b0;
      len_q      <= '0;
      tmo_cnt_q  <= '0;
`ifdef ROCKETCPU_DMA_IRQ_EN
      o_irq      <= 1'b0;
`endif
    end else begin
`ifdef ROCKETCPU_DMA_IRQ_EN
      o_irq <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (!i_en) begin
            o_wr_idx   <= '0;
            o_overflow <= 1'b0;
            o_timeout  <= 1'b0;
          end else if (!fifo_empty) begin
            o_wb_adr  <= base_aligned + {14'd0, o_wr_idx, 2'b00};
            o_wb_dat  <= fifo_mem[rd_ptr_q[FIFO_AW-1:0]];
            o_wb_sel  <= 4'hF;
            o_wb_we   <= 1'b1;
            o_wb_cyc  <= 1'b1;
            len_q     <= i_len;
            tmo_cnt_q <= '0;
            state_q   <= StReq;
          end
        end
        StReq: begin
          if (xfer_done) begin
            o_wb_sel <= '0;
            o_wb_we  <= 1'b0;
            o_wb_cyc <= 1'b0;
            o_wr_idx <= idx_next;
            if (!i_wb_ack) o_timeout <= 1'b1;
`ifdef ROCKETCPU_DMA_IRQ_EN
            o_irq <= ((idx_next == 16'd0) && !i_irq_mask[0]) ||
                     ((idx_next == (len_q >> 1)) && !i_irq_mask[1]);
`endif
            state_q <= StGap;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
        end
        StGap: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
      if (drop) o_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rocketcpu_wb_sample_dma.sv
// Directed self-checking bench for rocketcpu_wb_sample_dma.
`timescale 1ns/1ps

module tb_rocketcpu_wb_sample_dma;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] base_adr;
  logic [15:0] len;
  logic [31:0] sample;
  logic        stb;
  logic [31:0] wb_adr, wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc;
  logic        ack;
  logic [15:0] wr_idx;
  logic        busy, overflow, timeout;
`ifdef ROCKETCPU_DMA_IRQ_EN
  logic        irq;
  logic [1:0]  irq_mask;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Slave model controls
  logic slave_en  = 1'b0;
  int   ack_delay = 2;

  // Bus monitor log
  logic [31:0] wr_adr_log[$];
  logic [31:0] wr_dat_log[$];
  logic [15:0] irq_log[$];
  int          rises   = 0;
  int          sel_bad = 0;
  logic        prev_cyc = 1'b0;

  rocketcpu_wb_sample_dma #(
    .FIFO_AW (2),
    .TIMEOUT (255)
  ) dut (
    .i_wb_clk     (clk),
    .i_wb_rst_n   (rst_n),
    .i_en         (en),
    .i_base_adr   (base_adr),
    .i_len        (len),
    .i_sample     (sample),
    .i_sample_stb (stb),
    .o_wb_adr     (wb_adr),
    .o_wb_dat     (wb_dat),
    .o_wb_sel     (wb_sel),
    .o_wb_we      (wb_we),
    .o_wb_cyc     (wb_cyc),
    .i_wb_ack     (ack),
    .o_wr_idx     (wr_idx),
    .o_busy       (busy),
    .o_overflow   (overflow),
    .o_timeout    (timeout)
`ifdef ROCKETCPU_DMA_IRQ_EN
    ,
    .o_irq        (irq),
    .i_irq_mask   (irq_mask)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave: ack ack_delay cycles after cyc rises, one-cycle pulse.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ack) begin
        ack = 1'b0;
        wait_cnt = 0;
      end else if (wb_cyc && slave_en) begin
        if (wait_cnt >= ack_delay) ack = 1'b1;
        else wait_cnt++;
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: log completed writes, cyc rises and bad sel/we.
  always @(negedge clk) begin
    if (wb_cyc && ack) begin
      wr_adr_log.push_back(wb_adr);
      wr_dat_log.push_back(wb_dat);
    end
    if (wb_cyc && !prev_cyc) rises++;
    if (wb_cyc && (wb_sel !== 4'hF)) sel_bad++;
    if (wb_we !== wb_cyc) sel_bad++;
    prev_cyc <= wb_cyc;
`ifdef ROCKETCPU_DMA_IRQ_EN
    if (irq) irq_log.push_back(wr_idx);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    sample = v;
    stb = 1'b1;
    tick();
    stb = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    stb = 1'b0;
    slave_en = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: busy still %b after %0d cycles, required 0", name, busy, budget);
    end
  endtask

  task automatic wait_cyc(input int budget, input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (!wb_cyc && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!wb_cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: cyc never rose within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b0;
    stb = 1'b0;
    base_adr = 32'h2000_0000;
    len = 16'd4;
    sample = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({wb_cyc, wb_we, wb_sel} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_bus_ctl: got cyc/we/sel=%b, required 0", {wb_cyc, wb_we, wb_sel});
    end
    n_checks++;
    if ({wb_adr, wb_dat} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_adr_dat: got adr=%h dat=%h, required 0", wb_adr, wb_dat);
    end
    n_checks++;
    if ({wr_idx, busy, overflow, timeout} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_status: got idx=%0d busy=%b ov=%b to=%b, required 0",
               wr_idx, busy, overflow, timeout);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_circular();
    int n0, r0, b0;
    logic [31:0] exp_adr;
    do_reset();
    en = 1'b1;
    base_adr = 32'h2000_0000;
    len = 16'd4;
    ack_delay = 2;
    slave_en = 1'b1;
    n0 = wr_adr_log.size();
    r0 = rises;
    b0 = sel_bad;
    push(32'hA0);
    @(negedge clk);
    n_checks++;
    if (wb_cyc !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_n1: cyc=%b at N+1, required 0", wb_cyc);
    end
    @(negedge clk);
    n_checks++;
    if (wb_cyc !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_n2: cyc=%b at N+2, required 1", wb_cyc);
    end
    for (int i = 1; i < 6; i++) begin
      repeat (8) tick();
      push(32'hA0 + 32'(i));
    end
    wait_idle(200, "circ_idle");
    n_checks++;
    if (wr_adr_log.size() - n0 != 6) begin
      n_fail++;
      $display("FAIL circ_count: got %0d writes, required 6", wr_adr_log.size() - n0);
    end else begin
      for (int i = 0; i < 6; i++) begin
        exp_adr = 32'h2000_0000 + 32'((i % 4) * 4);
        n_checks++;
        if (wr_adr_log[n0+i] !== exp_adr || wr_dat_log[n0+i] !== 32'hA0 + 32'(i)) begin
          n_fail++;
          $display("FAIL circ_write%0d: got adr=%h dat=%h, required adr=%h dat=%h", i,
                   wr_adr_log[n0+i], wr_dat_log[n0+i], exp_adr, 32'hA0 + 32'(i));
        end
      end
    end
    n_checks++;
    if (wr_idx !== 16'd2) begin
      n_fail++;
      $display("FAIL circ_idx: got %0d, required 2", wr_idx);
    end
    n_checks++;
    if (rises - r0 != 6 || sel_bad != b0) begin
      n_fail++;
      $display("FAIL circ_framing: got %0d cyc rises, %0d bad sel/we, required 6 and 0",
               rises - r0, sel_bad - b0);
    end
  endtask

  task automatic test_overflow();
    int n0;
    do_reset();
    en = 1'b1;
    base_adr = 32'h2000_0000;
    len = 16'd16;
    ack_delay = 20;
    slave_en = 1'b1;
    n0 = wr_adr_log.size();
    for (int i = 0; i < 6; i++) begin
      sample = 32'hB0 + 32'(i);
      stb = 1'b1;
      tick();
    end
    stb = 1'b0;
    @(negedge clk);
    n_checks++;
    if (overflow !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_flag: got ov=%b busy=%b, required 1 1", overflow, busy);
    end
    wait_idle(400, "ovf_idle");
    n_checks++;
    if (wr_adr_log.size() - n0 != 5) begin
      n_fail++;
      $display("FAIL ovf_count: got %0d writes, required 5", wr_adr_log.size() - n0);
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (wr_dat_log[n0+i] !== 32'hB0 + 32'(i) ||
            wr_adr_log[n0+i] !== 32'h2000_0000 + 32'(4 * i)) begin
          n_fail++;
          $display("FAIL ovf_write%0d: got adr=%h dat=%h, required adr=%h dat=%h", i,
                   wr_adr_log[n0+i], wr_dat_log[n0+i], 32'h2000_0000 + 32'(4 * i),
                   32'hB0 + 32'(i));
        end
      end
    end
    n_checks++;
    if (wr_idx !== 16'd5 || overflow !== 1'b1 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_end: got idx=%0d ov=%b to=%b, required 5 1 0",
               wr_idx, overflow, timeout);
    end
  endtask

  task automatic test_timeout();
    int n0, cnt;
    do_reset();
    en = 1'b1;
    base_adr = 32'h2000_0000;
    len = 16'd4;
    slave_en = 1'b0;
    n0 = wr_adr_log.size();
    push(32'hC0);
    wait_cyc(10, "tmo_start");
    cnt = 0;
    while (wb_cyc === 1'b1 && cnt < 400) begin
      cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (cnt != 255) begin
      n_fail++;
      $display("FAIL tmo_len: cyc high %0d cycles, required 255", cnt);
    end
    n_checks++;
    if (timeout !== 1'b1 || wr_idx !== 16'd1 || wr_adr_log.size() != n0) begin
      n_fail++;
      $display("FAIL tmo_state: got to=%b idx=%0d writes=%0d, required 1 1 0",
               timeout, wr_idx, wr_adr_log.size() - n0);
    end
    slave_en = 1'b1;
    ack_delay = 2;
    tick();
    push(32'hC1);
    wait_idle(100, "tmo_idle");
    n_checks++;
    if (wr_adr_log.size() != n0 + 1 || wr_adr_log[$] !== 32'h2000_0004 ||
        wr_dat_log[$] !== 32'hC1 || timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_next: got adr=%h dat=%h to=%b, required 20000004 000000c1 1",
               wr_adr_log[$], wr_dat_log[$], timeout);
    end
  endtask

  task automatic test_reset_mid();
    slave_en = 1'b0;
    push(32'hD0);
    wait_cyc(10, "rmid_start");
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({wb_cyc, wb_we, wb_adr, wb_dat} !== 66'd0) begin
      n_fail++;
      $display("FAIL rmid_bus: got cyc=%b adr=%h dat=%h, required 0", wb_cyc, wb_adr, wb_dat);
    end
    n_checks++;
    if ({wr_idx, overflow, timeout, busy} !== 19'd0) begin
      n_fail++;
      $display("FAIL rmid_status: got idx=%0d ov=%b to=%b busy=%b, required 0",
               wr_idx, overflow, timeout, busy);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    slave_en = 1'b1;
    tick();
    push(32'hD1);
    wait_idle(100, "rmid_idle");
    n_checks++;
    if (wr_adr_log[$] !== 32'h2000_0000 || wr_dat_log[$] !== 32'hD1) begin
      n_fail++;
      $display("FAIL rmid_next: got adr=%h dat=%h, required 20000000 000000d1",
               wr_adr_log[$], wr_dat_log[$]);
    end
  endtask

  task automatic test_disable();
    int n0;
    do_reset();
    en = 1'b1;
    base_adr = 32'h2000_0000;
    len = 16'd16;
    ack_delay = 20;
    slave_en = 1'b1;
    n0 = wr_adr_log.size();
    for (int i = 0; i < 6; i++) begin
      sample = 32'hE0 + 32'(i);
      stb = 1'b1;
      tick();
    end
    stb = 1'b0;
    en = 1'b0;
    wait_idle(100, "dis_idle");
    n_checks++;
    if (wr_adr_log.size() != n0 + 1 || wr_dat_log[$] !== 32'hE0) begin
      n_fail++;
      $display("FAIL dis_writes: got %0d writes last dat=%h, required 1 and e0",
               wr_adr_log.size() - n0, wr_dat_log[$]);
    end
    n_checks++;
    if (wr_idx !== 16'd0 || overflow !== 1'b0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL dis_rewind: got idx=%0d ov=%b to=%b, required 0 0 0",
               wr_idx, overflow, timeout);
    end
    push(32'hE9);
    repeat (5) tick();
    n_checks++;
    if (busy !== 1'b0 || wr_adr_log.size() != n0 + 1) begin
      n_fail++;
      $display("FAIL dis_ignore: got busy=%b writes=%0d, required 0 1",
               busy, wr_adr_log.size() - n0);
    end
    en = 1'b1;
    ack_delay = 2;
    push(32'hEA);
    wait_idle(100, "dis_reen");
    n_checks++;
    if (wr_adr_log[$] !== 32'h2000_0000 || wr_dat_log[$] !== 32'hEA) begin
      n_fail++;
      $display("FAIL dis_reen: got adr=%h dat=%h, required 20000000 000000ea",
               wr_adr_log[$], wr_dat_log[$]);
    end
  endtask

  task automatic test_wrap_len0();
    int n0;
    logic [31:0] exp_adr [4];
    exp_adr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    do_reset();
    en = 1'b1;
    base_adr = 32'hFFFF_FFFB;
    len = 16'd4;
    ack_delay = 1;
    slave_en = 1'b1;
    n0 = wr_adr_log.size();
    for (int i = 0; i < 4; i++) begin
      push(32'hF0 + 32'(i));
      repeat (8) tick();
    end
    wait_idle(100, "wrap_idle");
    n_checks++;
    if (wr_adr_log.size() - n0 != 4) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d writes, required 4", wr_adr_log.size() - n0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (wr_adr_log[n0+i] !== exp_adr[i]) begin
          n_fail++;
          $display("FAIL wrap_adr%0d: got %h, required %h", i, wr_adr_log[n0+i], exp_adr[i]);
        end
      end
    end
    len = 16'd0;
    n0 = wr_adr_log.size();
    push(32'hF9);
    repeat (5) tick();
    n_checks++;
    if (busy !== 1'b0 || overflow !== 1'b0 || wr_adr_log.size() != n0) begin
      n_fail++;
      $display("FAIL len0_discard: got busy=%b ov=%b writes=%0d, required 0 0 0",
               busy, overflow, wr_adr_log.size() - n0);
    end
  endtask

`ifdef ROCKETCPU_DMA_IRQ_EN
  task automatic test_irq();
    int i0;
    do_reset();
    irq_mask = 2'b00;
    en = 1'b1;
    base_adr = 32'h2000_0000;
    len = 16'd8;
    ack_delay = 2;
    slave_en = 1'b1;
    i0 = irq_log.size();
    for (int i = 0; i < 8; i++) begin
      push(32'h10 + 32'(i));
      repeat (8) tick();
    end
    wait_idle(100, "irq_idle");
    n_checks++;
    if (irq_log.size() - i0 != 2 || irq_log[i0] !== 16'd4 || irq_log[i0+1] !== 16'd0) begin
      n_fail++;
      $display("FAIL irq_nomask: got %0d pulses, required 2 at idx 4 then 0",
               irq_log.size() - i0);
    end
    irq_mask = 2'b10;
    i0 = irq_log.size();
    for (int i = 0; i < 8; i++) begin
      push(32'h20 + 32'(i));
      repeat (8) tick();
    end
    wait_idle(100, "irq_idle2");
    n_checks++;
    if (irq_log.size() - i0 != 1 || irq_log[i0] !== 16'd0) begin
      n_fail++;
      $display("FAIL irq_mask_half: got %0d pulses, required 1 at idx 0",
               irq_log.size() - i0);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    stb = 1'b0;
    sample = '0;
    base_adr = '0;
    len = '0;
`ifdef ROCKETCPU_DMA_IRQ_EN
    irq_mask = 2'b00;
`endif
    test_reset();
    test_circular();
    test_overflow();
    test_timeout();
    test_reset_mid();
    test_disable();
    test_wrap_len0();
`ifdef ROCKETCPU_DMA_IRQ_EN
    test_irq();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
